// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock with registered carry
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [NCH-1:0][CHUNK-1:0]   a_q;
    logic [NCH-1:0][CHUNK-1:0]   b_q;
    logic [NCH-1:0][CHUNK-1:0]   part;
    logic [NCH-1:0][CHUNK-1:0]   part_nxt;
    logic                        carry;

    logic [CHUNK-1:0]            ca;
    logic [CHUNK-1:0]            cb;
    logic [CHUNK-1:0]            cs;
    logic                        cco;
    logic                        cmsb;

    // The carry into a bit is recoverable as sum ^ a ^ b, which also covers CHUNK == 1.
    always_comb begin
        ca                = a_q[cnt];
        cb                = b_q[cnt];
        {cco, cs}         = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
        cmsb              = cs[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
        part_nxt          = part;
        part_nxt[cnt]     = cs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part     <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    part  <= part_nxt;
                    carry <= cco;
                    if (cnt == LAST) begin
                        sum      <= part_nxt;
                        cout     <= cco;
                        overflow <= cmsb ^ cco;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - scoreboard bench for serial_chunk_adder (16/4 and 8/8 instances)
module tb_serial_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st16, sb16, ci16, busy16, done16, co16, ov16;
    logic [15:0] a16, b16, sum16;
    logic        st8, sb8, ci8, busy8, done8, co8, ov8;
    logic [7:0]  a8, b8, sum8;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(st16), .sub(sb16), .a(a16), .b(b16), .cin(ci16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(co16), .overflow(ov16)
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .sub(sb8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(co8), .overflow(ov8)
    );

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        int          e0;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_done16 = 0;
    int   n_done8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, cout, sum}; overflow from operand/result sign bits.
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] ia, ib,
                                            input logic ici, isb);
        logic [16:0] m17;
        logic [15:0] mask, am, beff, s;
        logic [16:0] full;
        logic        c, ov;
        m17  = (17'd1 << w) - 17'd1;
        mask = m17[15:0];
        am   = ia & mask;
        beff = (isb ? ~ib : ib) & mask;
        full = {1'b0, am} + {1'b0, beff} + {16'b0, isb ? ~ici : ici};
        s    = full[15:0] & mask;
        c    = full[w];
        ov   = (am[w-1] == beff[w-1]) && (s[w-1] != am[w-1]);
        return {ov, c, s};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done16) begin
            n_done16++;
            if (q16.size() == 0) begin
                check("done16_unexpected", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                check("sum16", {16'b0, sum16}, {16'b0, e.sum});
                check("cout16", {31'b0, co16}, {31'b0, e.co});
                check("ovf16", {31'b0, ov16}, {31'b0, e.ov});
                check("lat16", cyc - e.e0, 32'd4);
            end
        end
        if (done8) begin
            n_done8++;
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("sum8", {24'b0, sum8}, {24'b0, e.sum[7:0]});
                check("cout8", {31'b0, co8}, {31'b0, e.co});
                check("ovf8", {31'b0, ov8}, {31'b0, e.ov});
                check("lat8", cyc - e.e0, 32'd1);
            end
        end
    end

    // Callers invoke the start tasks from a negedge, with the instance not busy.
    task automatic start16x(input logic [15:0] ia, ib, input logic ici, isb,
                            input logic [15:0] es, input logic eco, eov);
        exp_t e;
        a16 = ia; b16 = ib; ci16 = ici; sb16 = isb; st16 = 1'b1;
        @(posedge clk);
        #1;
        e.sum = es; e.co = eco; e.ov = eov; e.e0 = cyc;
        q16.push_back(e);
        st16 = 1'b0;
    endtask

    task automatic start16(input logic [15:0] ia, ib, input logic ici, isb);
        logic [17:0] r;
        r = ref_add(16, ia, ib, ici, isb);
        start16x(ia, ib, ici, isb, r[15:0], r[16], r[17]);
    endtask

    task automatic start8x(input logic [7:0] ia, ib, input logic ici, isb,
                           input logic [7:0] es, input logic eco, eov);
        exp_t e;
        a8 = ia; b8 = ib; ci8 = ici; sb8 = isb; st8 = 1'b1;
        @(posedge clk);
        #1;
        e.sum = {8'b0, es}; e.co = eco; e.ov = eov; e.e0 = cyc;
        q8.push_back(e);
        st8 = 1'b0;
    endtask

    task automatic start8(input logic [7:0] ia, ib, input logic ici, isb);
        logic [17:0] r;
        r = ref_add(8, {8'b0, ia}, {8'b0, ib}, ici, isb);
        start8x(ia, ib, ici, isb, r[7:0], r[16], r[17]);
    endtask

    task automatic wait_done16();
        int k = 0;
        @(negedge clk);
        while (!done16 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done16) check("timeout16", 32'd0, 32'd1);
    endtask

    task automatic wait_done8();
        int k = 0;
        @(negedge clk);
        while (!done8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done8) check("timeout8", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd0;
        int d1;
        rst = 1'b1;
        st16 = 1'b0; sb16 = 1'b0; ci16 = 1'b0; a16 = '0; b16 = '0;
        st8 = 1'b0;  sb8 = 1'b0;  ci8 = 1'b0;  a8 = '0;  b8 = '0;
        #12;
        check("rst_busy16", {31'b0, busy16}, 32'd0);
        check("rst_done16", {31'b0, done16}, 32'd0);
        check("rst_sum16", {16'b0, sum16}, 32'd0);
        check("rst_cout16", {31'b0, co16}, 32'd0);
        check("rst_ovf16", {31'b0, ov16}, 32'd0);
        check("rst_busy8", {31'b0, busy8}, 32'd0);
        check("rst_sum8", {24'b0, sum8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start16x(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_busy", {31'b0, busy16}, 32'd1);
            check("t1_nodone", {31'b0, done16}, 32'd0);
        end
        @(negedge clk);
        check("t1_done", {31'b0, done16}, 32'd1);
        check("t1_idle", {31'b0, busy16}, 32'd0);
        @(negedge clk);
        check("t1_pulse", {31'b0, done16}, 32'd0);

        start16x(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        wait_done16(); @(negedge clk);
        start16x(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        wait_done16(); @(negedge clk);
        start16x(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        wait_done16(); @(negedge clk);
        start16x(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        wait_done16(); @(negedge clk);
        start16x(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
        wait_done16(); @(negedge clk);

        // start held high with fresh operands through every busy edge
        nd0 = n_done16;
        start16(16'h0F0F, 16'h1111, 1'b1, 1'b0);
        st16 = 1'b1;
        repeat (4) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            sb16 = 1'($urandom); ci16 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        st16 = 1'b0;
        repeat (6) @(negedge clk);
        check("ignored_start_dones", n_done16 - nd0, 32'd1);

        start16(16'hA5A5, 16'h1357, 1'b0, 1'b0);
        wait_done16();
        d1 = cyc;
        start16(16'h3C3C, 16'h0F0F, 1'b1, 1'b1);
        wait_done16();
        check("b2b_spacing", cyc - d1, 32'd5);
        @(negedge clk);

        start16x(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy16}, 32'd0);
        check("arst_done", {31'b0, done16}, 32'd0);
        check("arst_sum", {16'b0, sum16}, 32'd0);
        q16.delete();
        @(negedge clk);
        rst = 1'b0;
        nd0 = n_done16;
        repeat (8) @(negedge clk);
        check("arst_no_done", n_done16 - nd0, 32'd0);
        start16x(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        wait_done16(); @(negedge clk);

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    start16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                    wait_done16();
                    if ($urandom_range(1, 0) == 1) @(negedge clk);
                end
            end
            begin
                start8x(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
                wait_done8(); @(negedge clk);
                start8x(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
                wait_done8(); @(negedge clk);
                for (int j = 0; j < 300; j++) begin
                    start8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                    wait_done8();
                    if ($urandom_range(1, 0) == 1) @(negedge clk);
                end
            end
        join

        repeat (3) @(negedge clk);
        check("q16_drained", q16.size(), 32'd0);
        check("q8_drained", q8.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
